// File: rtl/riscv_defines.sv
// -----------------------------------------------------------------------------
// riscv_defines
// Shared type definitions for the DIFT (dynamic information flow tracking)
// trap path.
//   dift_trap_t       : trap type reported by the tag check unit
//   dift_trap_state_t : state of the trap controller exception FSM
//   dift_is_event     : qualifies a trap pulse as a real violation event
// -----------------------------------------------------------------------------
package riscv_defines;

  typedef enum logic [2:0] {
    DIFT_TRAP_TYPE_NONE   = 3'd0,
    DIFT_TRAP_TYPE_EXEC   = 3'd1,
    DIFT_TRAP_TYPE_ALU    = 3'd2,
    DIFT_TRAP_TYPE_BRANCH = 3'd3,
    DIFT_TRAP_TYPE_JALR   = 3'd4,
    DIFT_TRAP_TYPE_LOAD   = 3'd5,
    DIFT_TRAP_TYPE_STOR   = 3'd6
  } dift_trap_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } dift_trap_state_t;

  // A trap pulse carrying type NONE is not a violation and is dropped.
  function automatic logic dift_is_event(input logic trap, input dift_trap_t ttype);
    return trap && (ttype != DIFT_TRAP_TYPE_NONE);
  endfunction

endpackage

// File: rtl/dift_trap_log.sv
// -----------------------------------------------------------------------------
// dift_trap_log
// First-word-fall-through FIFO recording {type, PC} of every violation event.
// Parameter DEPTH must be a power of two, at least 2 (pointers wrap naturally).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push_i            : write {type_i, pc_i}
//   pop_i             : remove head (ignored when empty)
//   clr_i             : empty the FIFO and clear overflow (beats push/pop)
//   valid_o           : FIFO non-empty
//   type_o, pc_o      : head entry (NONE / 0 when empty)
//   ovf_o             : sticky, set when a push to a full FIFO is dropped
// -----------------------------------------------------------------------------
module dift_trap_log
  import riscv_defines::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  dift_trap_t  type_i,
  input  logic [31:0] pc_i,
  input  logic        pop_i,
  input  logic        clr_i,
  output logic        valid_o,
  output dift_trap_t  type_o,
  output logic [31:0] pc_o,
  output logic        ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  dift_trap_t  mem_type_q [DEPTH];
  logic [31:0] mem_pc_q   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic full_s, empty_s, pop_s, push_s;

  assign full_s  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_s = (cnt_q == '0);
  assign pop_s   = pop_i && !empty_s;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_s  = push_i && (!full_s || pop_s);

  // Next-state for pointers, occupancy and overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      if (push_i && !push_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; contents are only observed through valid pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s && !clr_i) begin
      mem_type_q[wr_ptr_q] <= type_i;
      mem_pc_q[wr_ptr_q]   <= pc_i;
    end
  end

  assign valid_o = !empty_s;
  assign type_o  = empty_s ? DIFT_TRAP_TYPE_NONE : mem_type_q[rd_ptr_q];
  assign pc_o    = empty_s ? 32'h0 : mem_pc_q[rd_ptr_q];
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/dift_trap_ctrl.sv
// -----------------------------------------------------------------------------
// dift_trap_ctrl
// Turns DIFT trap pulses into an exception request held until acknowledged,
// counts violations (saturating) and optionally records them in a trap log.
// Optional feature macro: DIFT_TRAP_LOG_EN (enables the trap log FIFO).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   trap_i/trap_type_i/trap_pc_i : trap pulse with type and PC
//   exc_req_o, exc_ack_i      : exception request / acknowledge handshake
//   exc_cause_o, exc_pc_o     : pending trap type and PC (NONE / 0 when idle)
//   viol_cnt_o, cnt_clr_i     : saturating violation counter and its clear
//   log_rd_i, log_clr_i       : log pop and log clear
//   log_valid_o, log_type_o, log_pc_o, log_ovf_o : log head and overflow flag
// -----------------------------------------------------------------------------
module dift_trap_ctrl
  import riscv_defines::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trap_i,
  input  dift_trap_t           trap_type_i,
  input  logic [31:0]          trap_pc_i,
  output logic                 exc_req_o,
  input  logic                 exc_ack_i,
  output dift_trap_t           exc_cause_o,
  output logic [31:0]          exc_pc_o,
  output logic [CNT_WIDTH-1:0] viol_cnt_o,
  input  logic                 cnt_clr_i,
  input  logic                 log_rd_i,
  output logic                 log_valid_o,
  output dift_trap_t           log_type_o,
  output logic [31:0]          log_pc_o,
  output logic                 log_ovf_o,
  input  logic                 log_clr_i
);

  dift_trap_state_t     state_q, state_d;
  dift_trap_t           cause_q, cause_d;
  logic [31:0]          pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 event_s;

  assign event_s = dift_is_event(trap_i, trap_type_i);

  // Exception FSM next-state; cause/PC are zeroed whenever the FSM goes idle.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (event_s) begin
          state_d = REQ;
          cause_d = trap_type_i;
          pc_d    = trap_pc_i;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (exc_ack_i && event_s) begin
          // Back-to-back: next request follows without a low cycle.
          state_d = REQ;
          cause_d = trap_type_i;
          pc_d    = trap_pc_i;
        end else if (exc_ack_i) begin
          state_d = IDLE;
          cause_d = DIFT_TRAP_TYPE_NONE;
          pc_d    = 32'h0;
        end else begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        cause_d = DIFT_TRAP_TYPE_NONE;
        pc_d    = 32'h0;
      end
    endcase
  end

  // Saturating violation counter; clear wins over a same-cycle event.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (event_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM, pending trap and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= DIFT_TRAP_TYPE_NONE;
      pc_q    <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exc_req_o   = (state_q == REQ);
  assign exc_cause_o = cause_q;
  assign exc_pc_o    = pc_q;
  assign viol_cnt_o  = cnt_q;

`ifdef DIFT_TRAP_LOG_EN
  dift_trap_log #(
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .rst     (rst),
    .push_i  (event_s),
    .type_i  (trap_type_i),
    .pc_i    (trap_pc_i),
    .pop_i   (log_rd_i),
    .clr_i   (log_clr_i),
    .valid_o (log_valid_o),
    .type_o  (log_type_o),
    .pc_o    (log_pc_o),
    .ovf_o   (log_ovf_o)
  );
`else
  logic unused_log_s;
  assign unused_log_s = ^{log_rd_i, log_clr_i, LOG_DEPTH[0]};
  assign log_valid_o  = 1'b0;
  assign log_type_o   = DIFT_TRAP_TYPE_NONE;
  assign log_pc_o     = 32'h0;
  assign log_ovf_o    = 1'b0;
`endif

endmodule

// File: tb/tb_dift_trap_ctrl.sv
module tb_dift_trap_ctrl;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_i = 1'b0;
  dift_trap_t  trap_type_i = DIFT_TRAP_TYPE_NONE;
  logic [31:0] trap_pc_i = 32'h0;
  logic        exc_req_o;
  logic        exc_ack_i = 1'b0;
  dift_trap_t  exc_cause_o;
  logic [31:0] exc_pc_o;
  logic [3:0]  viol_cnt_o;
  logic        cnt_clr_i = 1'b0;
  logic        log_rd_i = 1'b0;
  logic        log_valid_o;
  dift_trap_t  log_type_o;
  logic [31:0] log_pc_o;
  logic        log_ovf_o;
  logic        log_clr_i = 1'b0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dift_trap_ctrl #(.CNT_WIDTH(4), .LOG_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .trap_i(trap_i), .trap_type_i(trap_type_i),
    .trap_pc_i(trap_pc_i), .exc_req_o(exc_req_o), .exc_ack_i(exc_ack_i),
    .exc_cause_o(exc_cause_o), .exc_pc_o(exc_pc_o), .viol_cnt_o(viol_cnt_o),
    .cnt_clr_i(cnt_clr_i), .log_rd_i(log_rd_i), .log_valid_o(log_valid_o),
    .log_type_o(log_type_o), .log_pc_o(log_pc_o), .log_ovf_o(log_ovf_o),
    .log_clr_i(log_clr_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus, then all strobes return low.
  task automatic cyc(input logic trap, input dift_trap_t t, input logic [31:0] pc,
                     input logic ack, input logic rd);
    trap_i = trap; trap_type_i = t; trap_pc_i = pc; exc_ack_i = ack; log_rd_i = rd;
    tick();
    trap_i = 1'b0; trap_type_i = DIFT_TRAP_TYPE_NONE; trap_pc_i = 32'h0;
    exc_ack_i = 1'b0; log_rd_i = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   32'(exc_req_o),   32'h0);
    check({tag, "_cause"}, 32'(exc_cause_o), 32'h0);
    check({tag, "_pc"},    exc_pc_o,         32'h0);
    check({tag, "_cnt"},   32'(viol_cnt_o),  32'h0);
    check({tag, "_lval"},  32'(log_valid_o), 32'h0);
    check({tag, "_lovf"},  32'(log_ovf_o),   32'h0);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check_reset_state("rst0");

    // Type NONE is not an event.
    cyc(1'b1, DIFT_TRAP_TYPE_NONE, 32'h0000_0bad, 1'b0, 1'b0);
    check("none_req", 32'(exc_req_o), 32'h0);
    check("none_cnt", 32'(viol_cnt_o), 32'h0);
    check("none_lval", 32'(log_valid_o), 32'h0);

    // First event: request one cycle later, held until ack.
    cyc(1'b1, DIFT_TRAP_TYPE_STOR, 32'h0000_1000, 1'b0, 1'b0);
    check("stor_req", 32'(exc_req_o), 32'h1);
    check("stor_cause", 32'(exc_cause_o), 32'(DIFT_TRAP_TYPE_STOR));
    check("stor_pc", exc_pc_o, 32'h0000_1000);
    check("stor_cnt", 32'(viol_cnt_o), 32'h1);
    tick(); tick();
    check("hold_req", 32'(exc_req_o), 32'h1);
    check("hold_pc", exc_pc_o, 32'h0000_1000);
    cyc(1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 1'b1, 1'b0);
    check("ack_req", 32'(exc_req_o), 32'h0);
    check("ack_cause", 32'(exc_cause_o), 32'h0);
    check("ack_pc", exc_pc_o, 32'h0);

    // Ack in IDLE ignored.
    cyc(1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 1'b1, 1'b0);
    check("idle_ack_req", 32'(exc_req_o), 32'h0);

    // Ack plus event while pending: stays in REQ with new trap.
    cyc(1'b1, DIFT_TRAP_TYPE_JALR, 32'h0000_3000, 1'b0, 1'b0);
    check("jalr_cause", 32'(exc_cause_o), 32'(DIFT_TRAP_TYPE_JALR));
    cyc(1'b1, DIFT_TRAP_TYPE_LOAD, 32'h0000_2004, 1'b1, 1'b0);
    check("b2b_req", 32'(exc_req_o), 32'h1);
    check("b2b_cause", 32'(exc_cause_o), 32'(DIFT_TRAP_TYPE_LOAD));
    check("b2b_pc", exc_pc_o, 32'h0000_2004);
    check("b2b_cnt", 32'(viol_cnt_o), 32'h3);

    // Events without ack do not disturb the pending request.
    cyc(1'b1, DIFT_TRAP_TYPE_EXEC, 32'h0000_4000, 1'b0, 1'b0);
    cyc(1'b1, DIFT_TRAP_TYPE_ALU,  32'h0000_5000, 1'b0, 1'b0);
    check("pend_cause", 32'(exc_cause_o), 32'(DIFT_TRAP_TYPE_LOAD));
    check("pend_pc", exc_pc_o, 32'h0000_2004);
    check("pend_cnt", 32'(viol_cnt_o), 32'h5);

`ifdef DIFT_TRAP_LOG_EN
    // Five pushes into a 4-deep log: overflow, first four kept in order.
    check("log_ovf", 32'(log_ovf_o), 32'h1);
    check("log_head_type", 32'(log_type_o), 32'(DIFT_TRAP_TYPE_STOR));
    check("log_pop0", log_pc_o, 32'h0000_1000); cyc(1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 1'b0, 1'b1);
    check("log_pop1", log_pc_o, 32'h0000_3000); cyc(1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 1'b0, 1'b1);
    check("log_pop2", log_pc_o, 32'h0000_2004); cyc(1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 1'b0, 1'b1);
    check("log_pop3", log_pc_o, 32'h0000_4000); cyc(1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 1'b0, 1'b1);
    check("log_empty", 32'(log_valid_o), 32'h0);
    cyc(1'b0, DIFT_TRAP_TYPE_NONE, 32'h0, 1'b0, 1'b1);
    check("log_empty_rd", 32'(log_valid_o), 32'h0);
    check("log_ovf_sticky", 32'(log_ovf_o), 32'h1);
    log_clr_i = 1'b1;
    tick();
    log_clr_i = 1'b0;
    check("log_clr_ovf", 32'(log_ovf_o), 32'h0);
    // Fill, then push+pop on full: both happen, no overflow.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, DIFT_TRAP_TYPE_BRANCH, 32'h0000_6000 + 32'(i * 4), 1'b0, 1'b0);
    cyc(1'b1, DIFT_TRAP_TYPE_EXEC, 32'h0000_7000, 1'b0, 1'b1);
    check("full_pp_ovf", 32'(log_ovf_o), 32'h0);
    check("full_pp_head", log_pc_o, 32'h0000_6004);
    check("full_pp_cnt", 32'(viol_cnt_o), 32'ha);
`else
    check("nolog_lval", 32'(log_valid_o), 32'h0);
    check("nolog_lovf", 32'(log_ovf_o), 32'h0);
    check("nolog_lpc", log_pc_o, 32'h0);
    cyc(1'b1, DIFT_TRAP_TYPE_EXEC, 32'h0000_7000, 1'b0, 1'b1);
    check("nolog_lval2", 32'(log_valid_o), 32'h0);
`endif

    // Reset while a request is pending (and with an event present) wins.
    check("pre_rst_req", 32'(exc_req_o), 32'h1);
    rst = 1'b1;
    cyc(1'b1, DIFT_TRAP_TYPE_STOR, 32'h0000_8000, 1'b0, 1'b0);
    rst = 1'b0;
    check_reset_state("rst1");

    // Counter saturation at 15 with 4 bits, then clear beats event.
    for (int i = 0; i < 17; i++)
      cyc(1'b1, DIFT_TRAP_TYPE_LOAD, 32'(i * 4), 1'b0, 1'b0);
    check("cnt_sat", 32'(viol_cnt_o), 32'hf);
    cnt_clr_i = 1'b1;
    cyc(1'b1, DIFT_TRAP_TYPE_LOAD, 32'h0000_9000, 1'b0, 1'b0);
    cnt_clr_i = 1'b0;
    check("cnt_clr", 32'(viol_cnt_o), 32'h0);
    cyc(1'b1, DIFT_TRAP_TYPE_LOAD, 32'h0000_9004, 1'b0, 1'b0);
    check("cnt_after_clr", 32'(viol_cnt_o), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dift_trap_ctrl.md
DIFT_TRAP_CTRL -- requirements
Module: dift_trap_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the violation counter.
REQ-002 SHALL have parameter LOG_DEPTH, default 4, trap-log entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port trap_i, input, 1, single-cycle trap pulse from the tag check unit.
REQ-006 SHALL have port trap_type_i, input, dift_trap_t, trap type, valid with trap_i.
REQ-007 SHALL have port trap_pc_i, input, 32, PC of the trapping instruction, valid with trap_i.
REQ-008 SHALL have port exc_req_o, output, 1, exception request to the controller.
REQ-009 SHALL have port exc_ack_i, input, 1, controller accepts the request.
REQ-010 SHALL have ports exc_cause_o (output, dift_trap_t) and exc_pc_o (output, 32), the pending trap's type and PC.
REQ-011 SHALL have port viol_cnt_o, output, CNT_WIDTH, the violation count.
REQ-012 SHALL have port cnt_clr_i, input, 1, clears the counter.
REQ-013 SHALL have port log_rd_i, input, 1, pops one log entry.
REQ-014 SHALL have ports log_valid_o (1), log_type_o (dift_trap_t), log_pc_o (32) and log_ovf_o (1), all outputs: log head and sticky overflow flag.
REQ-015 SHALL have port log_clr_i, input, 1, empties the log and clears log_ovf_o.

Function
REQ-016 An event SHALL be defined as trap_i=1 with trap_type_i != DIFT_TRAP_TYPE_NONE; trap_i with type NONE SHALL be ignored entirely.
REQ-017 The FSM SHALL have two states, IDLE and REQ; exc_req_o SHALL be 1 exactly in REQ.
REQ-018 In IDLE, an event in cycle N SHALL latch type and PC and enter REQ, so exc_req_o=1 from cycle N+1 (one-cycle latency).
REQ-019 In REQ, exc_req_o, exc_cause_o and exc_pc_o SHALL hold stable until a cycle with exc_ack_i=1.
REQ-020 In REQ, exc_ack_i=1 without an event SHALL return the FSM to IDLE.
REQ-021 In REQ, exc_ack_i=1 together with an event SHALL stay in REQ with the new type/PC latched, so exc_req_o has no low cycle.
REQ-022 In REQ, an event without exc_ack_i SHALL NOT alter the pending request; it is still counted and logged.
REQ-023 exc_ack_i SHALL be ignored in IDLE.
REQ-024 In IDLE, exc_cause_o SHALL be DIFT_TRAP_TYPE_NONE and exc_pc_o SHALL be 0.
REQ-025 viol_cnt_o SHALL increment by 1 per event and saturate at all-ones.
REQ-026 cnt_clr_i SHALL force viol_cnt_o to 0 on the next cycle, taking priority over a same-cycle event.

Reset
REQ-027 rst SHALL be sampled only on the rising edge of clk and SHALL take priority over all inputs.
REQ-028 After reset: FSM IDLE, exc_req_o=0, exc_cause_o=NONE, exc_pc_o=0, viol_cnt_o=0, log empty, log_valid_o=0, log_ovf_o=0.
REQ-029 Reset asserted while in REQ SHALL abandon the pending request with no acknowledge required.

Configuration
REQ-030 Macro DIFT_TRAP_LOG_EN SHALL enable the trap log.
REQ-031 With DIFT_TRAP_LOG_EN defined, each event SHALL push {type, PC} into a first-word-fall-through FIFO of LOG_DEPTH entries.
REQ-032 The log head SHALL appear on log_type_o and log_pc_o, with log_valid_o=1 while the log is non-empty.
REQ-033 log_rd_i with log_valid_o=1 SHALL pop the head; log_rd_i on an empty log SHALL be ignored.
REQ-034 A push to a full log SHALL be dropped and set log_ovf_o; a same-cycle pop and push on a full log SHALL both take effect, with no overflow.
REQ-035 log_clr_i SHALL empty the log and clear log_ovf_o, taking priority over a same-cycle push or pop.
REQ-036 Without DIFT_TRAP_LOG_EN, log outputs SHALL be tied to 0, log inputs ignored, and no FIFO storage synthesised; ports remain present.

Structure
REQ-037 dift_trap_t SHALL remain in riscv_defines; a new dift_trap_state_t enum (IDLE, REQ) SHALL be added there.
REQ-038 The log FIFO SHALL be a sub-module dift_trap_log, instantiated only under DIFT_TRAP_LOG_EN.

Verification
REQ-039 Scenario: event STOR, PC 0x0000_1000 in cycle 5 -> exc_req_o=1 from cycle 6, cause STOR, pc 0x1000; ack in cycle 9 -> exc_req_o=0 in cycle 10; viol_cnt_o=1.
REQ-040 Scenario: while in REQ (JALR), ack and event LOAD 0x2004 in the same cycle -> exc_req_o stays 1, cause LOAD, pc 0x2004; viol_cnt_o=2.
REQ-041 Scenario: CNT_WIDTH=4, 17 events -> viol_cnt_o=15; cnt_clr_i with an event in the same cycle -> viol_cnt_o=0.
REQ-042 Scenario: log enabled, LOG_DEPTH=4, 5 events with no reads -> log_ovf_o=1; four pops return the first four PCs in order, then log_valid_o=0.
REQ-043 Scenario: rst pulsed while in REQ with 2 log entries -> next cycle all outputs match REQ-028; trap_i with type NONE -> no response.
